// File: rtl/prog_counter.sv
// rtl/prog_counter.sv - programmable up/down counter with prescaler, wrap/saturate/one-shot modes
module prog_counter #(
  parameter int COUNTER_WIDTH = 10,
  parameter int PRESCALE      = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable_in,
  input  logic                     direction,
  input  logic [1:0]               mode,
  input  logic                     load,
  input  logic [COUNTER_WIDTH-1:0] load_value,
  input  logic [COUNTER_WIDTH-1:0] limit,
  input  logic [COUNTER_WIDTH-1:0] cmp_value,
  output logic [COUNTER_WIDTH-1:0] count,
  output logic                     trig_out,
  output logic                     cmp_out,
  output logic                     halted
);

  // Prescaler only needs to reach PRESCALE-1; keep at least one bit.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PRE_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [PW-1:0]            pre_q, pre_d;
  logic [COUNTER_WIDTH-1:0] count_d;
  logic                     trig_d;
  logic                     tick;
  logic                     at_term;

  assign tick    = enable_in && (pre_q == PRE_LAST);
  // Up terminal is inclusive of counts above LIMIT so a lowered LIMIT still wraps.
  assign at_term = direction ? (count == '0) : (count >= limit);
  assign halted  = (state_q == HALT);
  assign cmp_out = (count == cmp_value);

  // State register: reset discards everything, including a pending pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      pre_q    <= '0;
      count    <= '0;
      trig_out <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      count    <= count_d;
      trig_out <= trig_d;
    end
  end

  // Next-state logic: load beats step; steps only happen in RUN, prescaler always runs.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    count_d = count;
    trig_d  = 1'b0;

    if (enable_in) begin
      pre_d = tick ? '0 : (pre_q + PRE_ONE);
    end

    if (load) begin
      count_d = (load_value > limit) ? limit : load_value;
      pre_d   = '0;
      state_d = RUN;
    end else if (tick && (state_q == RUN)) begin
      if (!at_term) begin
        count_d = direction ? (count - CNT_ONE) : (count + CNT_ONE);
      end else begin
        trig_d = 1'b1;
        case (mode)
          2'b01:   count_d = count;
          2'b10:   state_d = HALT;
          default: count_d = direction ? limit : '0;
        endcase
      end
    end
  end

endmodule

// File: doc/prog_counter.md
PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 Parameter COUNTER_WIDTH, default 10, SHALL set the width of COUNT, LIMIT, LOAD_VALUE and CMP_VALUE.
REQ-002 Parameter PRESCALE, default 1, range 1..65535, SHALL set the number of qualified ENABLE_IN cycles per count step.
REQ-003 CLK  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 RESET  input  1  SHALL be a synchronous, active-high reset.
REQ-005 ENABLE_IN  input  1  SHALL be the count-enable qualifier, feeding the prescaler.
REQ-006 DIRECTION  input  1  SHALL select the count direction: 0 = up, 1 = down.
REQ-007 MODE  input  2  SHALL select the mode: 00 = wrap, 01 = saturate, 10 = one-shot, 11 = reserved (treated as wrap).
REQ-008 LOAD  input  1  SHALL be a synchronous load strobe.
REQ-009 LOAD_VALUE  input  COUNTER_WIDTH  SHALL be the value loaded on LOAD.
REQ-010 LIMIT  input  COUNTER_WIDTH  SHALL be the runtime maximum count (the up terminal).
REQ-011 CMP_VALUE  input  COUNTER_WIDTH  SHALL be the compare-match value.
REQ-012 COUNT  output  COUNTER_WIDTH  SHALL be the registered count.
REQ-013 TRIG_OUT  output  1  SHALL be the registered one-cycle terminal pulse.
REQ-014 CMP_OUT  output  1  SHALL be asserted while COUNT == CMP_VALUE.
REQ-015 HALTED  output  1  SHALL be high while the one-shot FSM is in HALT.

Function
REQ-016 Step definitions:
- "tick" = ENABLE_IN high while the prescaler equals PRESCALE-1.
- The prescaler increments on each ENABLE_IN cycle and wraps to 0 on a tick.
- The prescaler holds when ENABLE_IN is low.
- "step" = a tick while the FSM is in RUN.
REQ-017 The terminal SHALL be LIMIT when DIRECTION=0 and 0 when DIRECTION=1.
REQ-018 The counter is at terminal when either holds:
- up: COUNT >= LIMIT, so COUNT > LIMIT is also at terminal.
- down: COUNT == 0.
REQ-019 A step that is not at terminal SHALL change COUNT by exactly +1 (up) or -1 (down).
REQ-020 A step at terminal in wrap mode SHALL load COUNT with 0 (up) or LIMIT (down).
REQ-021 A step at terminal in saturate mode SHALL hold COUNT.
REQ-022 A step at terminal in one-shot mode SHALL hold COUNT and move the FSM from RUN to HALT.
REQ-023 TRIG_OUT SHALL be 1 in the cycle after any step taken at terminal, and 0 otherwise.
- Saturate mode: one pulse per step at terminal.
- One-shot mode: exactly one pulse.
REQ-024 The FSM SHALL have two states, RUN and HALT:
- HALT ignores ticks; COUNT is held.
- The prescaler keeps running in HALT.
- HALTED = (state == HALT).
- LOAD is the only exit from HALT.
REQ-025 LOAD SHALL take priority over a step:
- COUNT <= min(LOAD_VALUE, LIMIT).
- The prescaler is cleared to 0.
- The FSM goes to RUN.
- TRIG_OUT is 0 in the next cycle.
REQ-026 DIRECTION, MODE and LIMIT SHALL be sampled at each step; a change takes effect on the next step, with no glitch on COUNT.
REQ-027 A MODE change from one-shot to another mode while in HALT SHALL leave the FSM in HALT until LOAD.
REQ-028 CMP_OUT SHALL be a combinational compare of the COUNT register against CMP_VALUE.
REQ-029 All arithmetic SHALL be unsigned modulo 2^COUNTER_WIDTH; no intermediate result wider than COUNTER_WIDTH+1 bits.
REQ-030 With LIMIT=0 the counter SHALL stay at 0:
- wrap mode: TRIG_OUT pulses on every step.
- one-shot mode: the first step enters HALT.

Reset
REQ-031 RESET SHALL have priority over LOAD and ENABLE_IN.
REQ-032 On RESET, the following are set in the cycle after the edge:
- COUNT = 0.
- Prescaler = 0.
- TRIG_OUT = 0.
- FSM = RUN.
- HALTED = 0.
REQ-033 RESET asserted mid-count or in HALT SHALL discard all state, with no residual TRIG_OUT pulse.

Verification
REQ-034 Wrap up: W=4, LIMIT=5, PRESCALE=1, MODE=00, ENABLE_IN=1 -> COUNT 0,1,2,3,4,5,0,...; TRIG_OUT high in the cycle COUNT returns to 0.
REQ-035 Down with prescale: PRESCALE=3, LIMIT=5, DIRECTION=1 from COUNT=0 -> COUNT=5 after the 3rd enable, then decrements every 3 enables; TRIG_OUT pulses once per wrap.
REQ-036 Saturate: LIMIT=3, MODE=01, up, 6 steps -> COUNT 1,2,3,3,3,3; TRIG_OUT on the 4th, 5th and 6th step.
REQ-037 One-shot then LOAD: LIMIT=2, MODE=10, up -> COUNT 1,2,2; HALTED=1; a single TRIG_OUT pulse; LOAD with LOAD_VALUE=9 -> COUNT=2 (clamped), HALTED=0.
REQ-038 Priority: LOAD and step in the same cycle -> COUNT=LOAD_VALUE; RESET and LOAD together -> COUNT=0; LIMIT lowered to 2 while COUNT=7 (up, wrap) -> next step COUNT=0 with TRIG_OUT.
REQ-039 Compare: CMP_VALUE=4 -> CMP_OUT high exactly while COUNT=4 in every mode.
